// File: rtl/tpu_top.sv
// 5x5 output-stationary systolic matmul C = A*B over three word buffers.
// Ports: clk, rst (async, active-low), start, m/k/n (4b dims), done.
// Option: TPU_SAT_EN makes stored bytes saturate at 8'hFF.
module tpu_gbuff #(
  parameter int W     = 40,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] gbuff [DEPTH];

  always_ff @(posedge clk)
    if (we) gbuff[waddr] <= wdata;

  assign rdata = gbuff[raddr];
endmodule

module tpu_top #(
  parameter int DATA_W      = 8,
  parameter int ARRAY       = 5,
  parameter int WORD_SIZE   = 40,
  parameter int GBUFF_DEPTH = 256,
  parameter int AW          = 8,
  parameter int ACC_W       = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] m,
  input  logic [3:0] k,
  input  logic [3:0] n,
  output logic       done
);
`ifdef TPU_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMP, S_WRITE, S_DONE
  } state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [3:0] m_q, k_q, n_q;
  logic       dims_ok;
  logic       launch;

  logic [DATA_W-1:0] a_mat [ARRAY][ARRAY];
  logic [DATA_W-1:0] b_mat [ARRAY][ARRAY];
  logic [DATA_W-1:0] a_pe  [ARRAY][ARRAY];
  logic [DATA_W-1:0] b_pe  [ARRAY][ARRAY];
  logic [DATA_W-1:0] a_in  [ARRAY][ARRAY];
  logic [DATA_W-1:0] b_in  [ARRAY][ARRAY];
  logic [ACC_W-1:0]  acc   [ARRAY][ARRAY];
  logic [DATA_W-1:0] a_edge [ARRAY];
  logic [DATA_W-1:0] b_edge [ARRAY];

  logic [AW-1:0]        addr;
  logic [WORD_SIZE-1:0] a_rd, b_rd;
  logic [WORD_SIZE-1:0] out_wdata;
  logic [WORD_SIZE-1:0] out_rd_unused;
  logic                 out_we;

  assign addr   = {{(AW-4){1'b0}}, cnt};
  assign out_we = (state == S_WRITE);

  tpu_gbuff #(.W(WORD_SIZE), .DEPTH(GBUFF_DEPTH), .AW(AW)) GBUFF_A (
    .clk(clk), .we(1'b0), .waddr('0), .wdata('0),
    .raddr(addr), .rdata(a_rd)
  );

  tpu_gbuff #(.W(WORD_SIZE), .DEPTH(GBUFF_DEPTH), .AW(AW)) GBUFF_B (
    .clk(clk), .we(1'b0), .waddr('0), .wdata('0),
    .raddr(addr), .rdata(b_rd)
  );

  tpu_gbuff #(.W(WORD_SIZE), .DEPTH(GBUFF_DEPTH), .AW(AW)) GBUFF_OUT (
    .clk(clk), .we(out_we), .waddr(addr), .wdata(out_wdata),
    .raddr(addr), .rdata(out_rd_unused)
  );

  assign dims_ok = (m != 4'd0) && (m <= 4'd5) &&
                   (k != 4'd0) && (k <= 4'd5) &&
                   (n != 4'd0) && (n <= 4'd5);
  assign launch  = (state == S_IDLE) && start;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          cnt_nx   = 4'd0;
          state_nx = dims_ok ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        if (cnt == 4'd4) begin
          cnt_nx   = 4'd0;
          state_nx = S_COMP;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_COMP: begin
        if (cnt == 4'd12) begin
          cnt_nx   = 4'd0;
          state_nx = S_WRITE;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_WRITE: begin
        if (cnt == m_q - 4'd1) begin
          cnt_nx   = 4'd0;
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_DONE: begin
        if (!start) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      m_q   <= 4'd0;
      k_q   <= 4'd0;
      n_q   <= 4'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= (state_nx == S_DONE);
      if (launch) begin
        m_q <= m;
        k_q <= k;
        n_q <= n;
      end
    end
  end

  // Skew: row i / column j sees its k-th element at cycle k+i / k+j.
  always_comb begin
    for (int i = 0; i < ARRAY; i++) begin
      logic [3:0] d;
      d = cnt - 4'(i);
      a_edge[i] = '0;
      b_edge[i] = '0;
      if (state == S_COMP && cnt >= 4'(i) && d < 4'd5) begin
        a_edge[i] = a_mat[i][d[2:0]];
        b_edge[i] = b_mat[d[2:0]][i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ARRAY; i++) begin
      for (int j = 0; j < ARRAY; j++) begin
        a_in[i][j] = (j == 0) ? a_edge[i] : a_pe[i][(j == 0) ? 0 : j-1];
        b_in[i][j] = (i == 0) ? b_edge[j] : b_pe[(i == 0) ? 0 : i-1][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ARRAY; i++) begin
        for (int j = 0; j < ARRAY; j++) begin
          a_mat[i][j] <= '0;
          b_mat[i][j] <= '0;
          a_pe[i][j]  <= '0;
          b_pe[i][j]  <= '0;
          acc[i][j]   <= '0;
        end
      end
    end else if (launch) begin
      for (int i = 0; i < ARRAY; i++) begin
        for (int j = 0; j < ARRAY; j++) begin
          a_pe[i][j] <= '0;
          b_pe[i][j] <= '0;
          acc[i][j]  <= '0;
        end
      end
    end else if (state == S_LOAD) begin
      // Out-of-range k lanes are zeroed so they add nothing.
      for (int c = 0; c < ARRAY; c++) begin
        a_mat[cnt[2:0]][c] <= (4'(c) < k_q) ?
          a_rd[WORD_SIZE-1-DATA_W*c -: DATA_W] : '0;
        b_mat[cnt[2:0]][c] <= (cnt < k_q) ?
          b_rd[WORD_SIZE-1-DATA_W*c -: DATA_W] : '0;
      end
    end else if (state == S_COMP) begin
      for (int i = 0; i < ARRAY; i++) begin
        for (int j = 0; j < ARRAY; j++) begin
          a_pe[i][j] <= a_in[i][j];
          b_pe[i][j] <= b_in[i][j];
          acc[i][j]  <= acc[i][j] +
            ACC_W'(a_in[i][j]) * ACC_W'(b_in[i][j]);
        end
      end
    end
  end

  always_comb begin
    out_wdata = '0;
    for (int j = 0; j < ARRAY; j++) begin
      logic [ACC_W-1:0]  v;
      logic [DATA_W-1:0] b;
      v = acc[cnt[2:0]][j];
      b = (SAT_EN && (|v[ACC_W-1:DATA_W])) ? '1 : v[DATA_W-1:0];
      if (4'(j) < n_q)
        out_wdata[WORD_SIZE-1-DATA_W*j -: DATA_W] = b;
    end
  end
endmodule

// File: tb/tb_tpu_top.sv
// Directed self-checking bench for tpu_top.
// Preloads buffers hierarchically and checks results, latency, control.
module tb_tpu_top;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] m, k, n;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [39:0] a1 [5];
  logic [39:0] b1 [5];
  logic [39:0] g1 [5];
  logic [39:0] prev [5];
  logic [39:0] ff_row;

  tpu_top dut (
    .clk(clk), .rst(rst), .start(start),
    .m(m), .k(k), .n(n), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_case1();
    for (int i = 0; i < 5; i++) begin
      dut.GBUFF_A.gbuff[i] = a1[i];
      dut.GBUFF_B.gbuff[i] = b1[i];
    end
  endtask

  // Pulse start for one edge and count edges (launch edge = 1) to done.
  task automatic run(input logic [3:0] mm, input logic [3:0] kk,
                     input logic [3:0] nn, output int c);
    @(negedge clk);
    m = mm; k = kk; n = nn; start = 1'b1;
    @(posedge clk);
    c = 1;
    #1 start = 1'b0;
    while (!done && c < 100) begin
      @(posedge clk);
      c++;
      #1;
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    a1[0] = 40'h0001000000; a1[1] = 40'h0100000001;
    a1[2] = 40'h0000000001; a1[3] = 40'h0001010100;
    a1[4] = 40'h0100010101;
    b1[0] = 40'h0101010101; b1[1] = 40'h0000010101;
    b1[2] = 40'h0001000000; b1[3] = 40'h0000010101;
    b1[4] = 40'h0101000101;
    g1[0] = 40'h0000010101; g1[1] = 40'h0202010202;
    g1[2] = 40'h0101000101; g1[3] = 40'h0001020202;
    g1[4] = 40'h0203020303;
`ifdef TPU_SAT_EN
    ff_row = 40'hFFFFFFFFFF;
`else
    ff_row = 40'h0505050505;
`endif

    rst = 1'b0; start = 1'b0;
    m = 4'd0; k = 4'd0; n = 4'd0;
    load_case1();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_state", 64'(dut.state), 64'd0);
    @(negedge clk) rst = 1'b1;

    // Case 1: full 5x5
    run(4'd5, 4'd5, 4'd5, cyc);
    chk("c1_latency", 64'(cyc), 64'd24);
    for (int i = 0; i < 5; i++)
      chk($sformatf("c1_out%0d", i), 64'(dut.GBUFF_OUT.gbuff[i]), 64'(g1[i]));

    // Case 2: all-FF operands
    for (int i = 0; i < 5; i++) begin
      dut.GBUFF_A.gbuff[i] = 40'hFFFFFFFFFF;
      dut.GBUFF_B.gbuff[i] = 40'hFFFFFFFFFF;
    end
    run(4'd5, 4'd5, 4'd5, cyc);
    for (int i = 0; i < 5; i++)
      chk($sformatf("c2_out%0d", i), 64'(dut.GBUFF_OUT.gbuff[i]), 64'(ff_row));

    // Case 3: 2x3 by 3x4
    load_case1();
    run(4'd2, 4'd3, 4'd4, cyc);
    chk("c3_latency", 64'(cyc), 64'd21);
    prev[0] = 40'h0000010100;
    prev[1] = 40'h0101010100;
    prev[2] = ff_row; prev[3] = ff_row; prev[4] = ff_row;
    for (int i = 0; i < 5; i++)
      chk($sformatf("c3_out%0d", i), 64'(dut.GBUFF_OUT.gbuff[i]), 64'(prev[i]));

    // Case 4: k=0 is rejected immediately
    run(4'd5, 4'd0, 4'd5, cyc);
    chk("c4_fast_done", 64'(cyc <= 2), 64'd1);
    for (int i = 0; i < 5; i++)
      chk($sformatf("c4_out%0d", i), 64'(dut.GBUFF_OUT.gbuff[i]), 64'(prev[i]));

    // Case 5: reset during COMPUTE, then rerun
    @(negedge clk);
    m = 4'd5; k = 4'd5; n = 4'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("c5_rst_done", 64'(done), 64'd0);
    chk("c5_rst_state", 64'(dut.state), 64'd0);
    chk("c5_out0_kept", 64'(dut.GBUFF_OUT.gbuff[0]), 64'(prev[0]));
    @(negedge clk) rst = 1'b1;
    run(4'd5, 4'd5, 4'd5, cyc);
    chk("c5_latency", 64'(cyc), 64'd24);
    for (int i = 0; i < 5; i++)
      chk($sformatf("c5_out%0d", i), 64'(dut.GBUFF_OUT.gbuff[i]), 64'(g1[i]));

    // Case 6: level start holds done, release returns to IDLE
    @(negedge clk);
    m = 4'd1; k = 4'd1; n = 4'd1; start = 1'b1;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    chk("c6_latency", 64'(cyc), 64'd20);
    repeat (4) @(posedge clk);
    #1;
    chk("c6_hold_done", 64'(done), 64'd1);
    chk("c6_hold_state", 64'(dut.state), 64'd4);
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    #1;
    chk("c6_drop_done", 64'(done), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("c6_no_relaunch", 64'(dut.state), 64'd0);
    chk("c6_done_low", 64'(done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
